// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
// Holds the FSM state encoding and default widths, reset PC and timeout.
package fetch_pkg;

    localparam int unsigned ADDR_W_DEF   = 8;
    localparam int unsigned DATA_W_DEF   = 8;
    localparam logic [7:0]  RESET_PC_DEF = 8'h00;
    localparam int unsigned TIMEOUT_DEF  = 15;

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_SETTLE = 3'd1,
        S_FETCH  = 3'd2,
        S_WAIT   = 3'd3,
        S_HOLD   = 3'd4,
        S_UPDATE = 3'd5,
        S_ERROR  = 3'd6
    } fetch_state_e;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Memory-ack timeout counter: cleared on clr, counts while en.
// Ports: clk, rst (sync, active-high), clr, en in; hit out when the
// current enabled cycle is the TIMEOUT-th one without an ack.
module fetch_timeout_ctr #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    assign hit = en && (cnt_q == LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch FSM: initialises and advances the PC, reads
// instruction memory via req/ack and presents instructions valid/ready.
// Ports: clk, rst; pc_in / pc_wr_en / pc_next (PC side);
// mem_req / mem_addr / mem_ack / mem_rdata (memory side);
// instr_valid / instr_ready / instr_out / instr_pc (downstream);
// branch_valid / branch_target (redirect); fetch_err (sticky timeout).
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned        ADDR_W   = ADDR_W_DEF,
    parameter int unsigned        DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEF),
    parameter int unsigned        TIMEOUT  = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              pc_wr_en,
    output logic [ADDR_W-1:0] pc_next,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              fetch_err
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic              redir_q, redir_d;
    logic              pc_wr_en_q, pc_wr_en_d;
    logic [ADDR_W-1:0] pc_next_q, pc_next_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              instr_valid_q, instr_valid_d;
    logic [DATA_W-1:0] instr_out_q, instr_out_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              fetch_err_q, fetch_err_d;

    logic              ctr_clr, ctr_en, ctr_hit;
    logic              redir_pend;
    logic [ADDR_W-1:0] redir_addr;

    // A branch arriving this very cycle counts as pending and wins
    // over any previously latched target.
    assign redir_pend = redir_q | branch_valid;
    assign redir_addr = branch_valid ? branch_target : tgt_q;

    assign ctr_clr = (state_q == S_FETCH);
    assign ctr_en  = (state_q == S_WAIT) && !mem_ack;

    fetch_timeout_ctr #(
        .TIMEOUT(TIMEOUT)
    ) u_ctr (
        .clk(clk),
        .rst(rst),
        .clr(ctr_clr),
        .en (ctr_en),
        .hit(ctr_hit)
    );

    // Outputs are registered: each state computes what the outputs
    // show in the following cycle, so pc_wr_en lands in SETTLE and
    // mem_req/instr_valid line up with WAIT/HOLD.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        tgt_d         = tgt_q;
        redir_d       = redir_q;
        pc_wr_en_d    = 1'b0;
        pc_next_d     = pc_next_q;
        mem_req_d     = 1'b0;
        mem_addr_d    = mem_addr_q;
        instr_valid_d = 1'b0;
        instr_out_d   = instr_out_q;
        instr_pc_d    = instr_pc_q;
        fetch_err_d   = fetch_err_q;

        if (branch_valid && state_q != S_INIT && state_q != S_ERROR) begin
            redir_d = 1'b1;
            tgt_d   = branch_target;
        end

        unique case (state_q)
            S_INIT: begin
                pc_wr_en_d = 1'b1;
                pc_next_d  = RESET_PC;
                state_d    = S_SETTLE;
            end
            S_SETTLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                addr_d     = pc_in;
                mem_req_d  = 1'b1;
                mem_addr_d = pc_in;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (mem_ack) begin
                    if (redir_pend) begin
                        pc_wr_en_d = 1'b1;
                        pc_next_d  = redir_addr;
                        redir_d    = 1'b0;
                        state_d    = S_SETTLE;
                    end else begin
                        instr_valid_d = 1'b1;
                        instr_out_d   = mem_rdata;
                        instr_pc_d    = addr_q;
                        state_d       = S_HOLD;
                    end
                end else if (ctr_hit) begin
                    fetch_err_d = 1'b1;
                    state_d     = S_ERROR;
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (instr_ready) begin
                    state_d = S_UPDATE;
                end else begin
                    instr_valid_d = 1'b1;
                end
            end
            S_UPDATE: begin
                pc_wr_en_d = 1'b1;
                pc_next_d  = redir_pend ? redir_addr
                                        : instr_pc_q + ADDR_W'(1);
                redir_d    = 1'b0;
                state_d    = S_SETTLE;
            end
            S_ERROR: begin
                fetch_err_d = 1'b1;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_INIT;
            addr_q        <= '0;
            tgt_q         <= '0;
            redir_q       <= 1'b0;
            pc_wr_en_q    <= 1'b0;
            pc_next_q     <= '0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            instr_valid_q <= 1'b0;
            instr_out_q   <= '0;
            instr_pc_q    <= '0;
            fetch_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            tgt_q         <= tgt_d;
            redir_q       <= redir_d;
            pc_wr_en_q    <= pc_wr_en_d;
            pc_next_q     <= pc_next_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            instr_valid_q <= instr_valid_d;
            instr_out_q   <= instr_out_d;
            instr_pc_q    <= instr_pc_d;
            fetch_err_q   <= fetch_err_d;
        end
    end

    assign pc_wr_en    = pc_wr_en_q;
    assign pc_next     = pc_next_q;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign instr_valid = instr_valid_q;
    assign instr_out   = instr_out_q;
    assign instr_pc    = instr_pc_q;
    assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit with a PC register and a
// simple memory responder (rdata = addr ^ 8'h5A) driven from tasks.
module tb_instr_fetch_unit;

    logic       clk;
    logic       rst;
    logic [7:0] pc_in;
    logic       pc_wr_en;
    logic [7:0] pc_next;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr_out;
    logic [7:0] instr_pc;
    logic       branch_valid;
    logic [7:0] branch_target;
    logic       fetch_err;

    int checks = 0;
    int errors = 0;
    int req_cnt = 0;
    logic mem_auto = 1'b1;

    instr_fetch_unit #(
        .ADDR_W(8),
        .DATA_W(8),
        .RESET_PC(8'h00),
        .TIMEOUT(15)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pc_in(pc_in),
        .pc_wr_en(pc_wr_en),
        .pc_next(pc_next),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr_out(instr_out),
        .instr_pc(instr_pc),
        .branch_valid(branch_valid),
        .branch_target(branch_target),
        .fetch_err(fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // One clock: PC register takes the write, memory acks one
    // cycle after mem_req rises (when mem_auto is set).
    task automatic tick();
        logic       w;
        logic [7:0] n;
        w = pc_wr_en;
        n = pc_next;
        @(posedge clk);
        #1;
        if (w === 1'b1) pc_in = n;
        if (mem_req === 1'b1) begin
            req_cnt++;
            mem_ack = mem_auto && (req_cnt > 1);
        end else begin
            req_cnt = 0;
            mem_ack = 1'b0;
        end
        mem_rdata = mem_addr ^ 8'h5A;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pc_in = 8'h77;
        mem_ack = 1'b0;
        mem_rdata = 8'h00;
        instr_ready = 1'b0;
        branch_valid = 1'b0;
        branch_target = 8'h00;
        tick();
        tick();
        checks++;
        if ({pc_wr_en, pc_next, mem_req, mem_addr, instr_valid,
             instr_out, instr_pc, fetch_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got wr=%b nx=%h req=%b v=%b err=%b, want all 0",
                     pc_wr_en, pc_next, mem_req, instr_valid, fetch_err);
        end
    endtask

    task automatic test_seq_fetch();
        rst = 1'b0;
        tick();
        checks++;
        if (pc_wr_en !== 1'b1 || pc_next !== 8'h00) begin
            errors++;
            $display("FAIL init_write: wr=%b nx=%h, want 1/00", pc_wr_en, pc_next);
        end
        tick();
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin
            errors++;
            $display("FAIL first_req: req=%b addr=%h, want 1/00", mem_req, mem_addr);
        end
        tick();
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_out !== 8'h5A || instr_pc !== 8'h00) begin
            errors++;
            $display("FAIL first_instr: v=%b out=%h pc=%h, want 1/5a/00",
                     instr_valid, instr_out, instr_pc);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_drop: v=%b, want 0", instr_valid);
        end
        tick();
        checks++;
        if (pc_wr_en !== 1'b1 || pc_next !== 8'h01) begin
            errors++;
            $display("FAIL seq_next: wr=%b nx=%h, want 1/01", pc_wr_en, pc_next);
        end
        tick();
        checks++;
        if (pc_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL wr_single: wr=%b, want 0", pc_wr_en);
        end
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h01) begin
            errors++;
            $display("FAIL second_req: req=%b addr=%h, want 1/01", mem_req, mem_addr);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 20 && instr_valid !== 1'b1; i++) tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 8'h01 || instr_out !== 8'h5B) begin
            errors++;
            $display("FAIL instr_01: v=%b pc=%h out=%h, want 1/01/5b",
                     instr_valid, instr_pc, instr_out);
        end
        branch_valid = 1'b1;
        branch_target = 8'hFF;
        instr_ready = 1'b1;
        tick();
        branch_valid = 1'b0;
        instr_ready = 1'b0;
        tick();
        checks++;
        if (pc_wr_en !== 1'b1 || pc_next !== 8'hFF) begin
            errors++;
            $display("FAIL hold_branch: wr=%b nx=%h, want 1/ff", pc_wr_en, pc_next);
        end
        for (int i = 0; i < 20 && instr_valid !== 1'b1; i++) tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 8'hFF || instr_out !== 8'hA5) begin
            errors++;
            $display("FAIL instr_ff: v=%b pc=%h out=%h, want 1/ff/a5",
                     instr_valid, instr_pc, instr_out);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        for (int i = 0; i < 20 && pc_wr_en !== 1'b1; i++) tick();
        checks++;
        if (pc_wr_en !== 1'b1 || pc_next !== 8'h00) begin
            errors++;
            $display("FAIL wrap_next: wr=%b nx=%h, want 1/00", pc_wr_en, pc_next);
        end
        for (int i = 0; i < 20 && mem_req !== 1'b1; i++) tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin
            errors++;
            $display("FAIL wrap_addr: req=%b addr=%h, want 1/00", mem_req, mem_addr);
        end
    endtask

    task automatic test_hold_stall();
        int pulses;
        for (int i = 0; i < 20 && instr_valid !== 1'b1; i++) tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (instr_valid !== 1'b1 || instr_out !== 8'h5A || instr_pc !== 8'h00
                || pc_wr_en !== 1'b0) begin
                errors++;
                $display("FAIL stall_%0d: v=%b out=%h pc=%h wr=%b, want 1/5a/00/0",
                         i, instr_valid, instr_out, instr_pc, pc_wr_en);
            end
            tick();
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (pc_wr_en === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL stall_release: pulses=%0d, want 1", pulses);
        end
    endtask

    task automatic test_branch_on_ack();
        logic seen;
        branch_valid = 1'b1;
        branch_target = 8'h10;
        instr_ready = 1'b1;
        tick();
        branch_valid = 1'b0;
        instr_ready = 1'b0;
        for (int i = 0; i < 20 && mem_ack !== 1'b1; i++) tick();
        checks++;
        if (mem_ack !== 1'b1 || mem_addr !== 8'h10) begin
            errors++;
            $display("FAIL addr_10: ack=%b addr=%h, want 1/10", mem_ack, mem_addr);
        end
        branch_valid = 1'b1;
        branch_target = 8'h40;
        tick();
        branch_valid = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || pc_wr_en !== 1'b1 || pc_next !== 8'h40) begin
            errors++;
            $display("FAIL ack_branch: v=%b wr=%b nx=%h, want 0/1/40",
                     instr_valid, pc_wr_en, pc_next);
        end
        seen = 1'b0;
        for (int i = 0; i < 20 && mem_req !== 1'b1; i++) begin
            tick();
            if (instr_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || mem_addr !== 8'h40) begin
            errors++;
            $display("FAIL redirect_addr: seen_valid=%b addr=%h, want 0/40", seen, mem_addr);
        end
        for (int i = 0; i < 20 && instr_valid !== 1'b1; i++) tick();
        checks++;
        if (instr_pc !== 8'h40 || instr_out !== 8'h1A) begin
            errors++;
            $display("FAIL instr_40: pc=%h out=%h, want 40/1a", instr_pc, instr_out);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
    endtask

    task automatic test_timeout();
        int cnt;
        mem_auto = 1'b0;
        for (int i = 0; i < 20 && mem_req !== 1'b1; i++) tick();
        cnt = 0;
        while (mem_req === 1'b1 && cnt < 40) begin
            cnt++;
            tick();
        end
        checks++;
        if (cnt !== 15) begin
            errors++;
            $display("FAIL timeout_len: req cycles=%0d, want 15", cnt);
        end
        checks++;
        if (fetch_err !== 1'b1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err: err=%b req=%b, want 1/0", fetch_err, mem_req);
        end
        branch_valid = 1'b1;
        branch_target = 8'h22;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (fetch_err !== 1'b1 || mem_req !== 1'b0 || instr_valid !== 1'b0
                || pc_wr_en !== 1'b0) begin
                errors++;
                $display("FAIL error_sticky_%0d: err=%b req=%b v=%b wr=%b, want 1/0/0/0",
                         i, fetch_err, mem_req, instr_valid, pc_wr_en);
            end
        end
        branch_valid = 1'b0;
        rst = 1'b1;
        tick();
        checks++;
        if (fetch_err !== 1'b0 || pc_wr_en !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL err_reset: err=%b wr=%b req=%b, want 0/0/0",
                     fetch_err, pc_wr_en, mem_req);
        end
        rst = 1'b0;
        mem_auto = 1'b1;
        tick();
        checks++;
        if (pc_wr_en !== 1'b1 || pc_next !== 8'h00) begin
            errors++;
            $display("FAIL err_restart: wr=%b nx=%h, want 1/00", pc_wr_en, pc_next);
        end
    endtask

    task automatic test_reset_mid_wait();
        for (int i = 0; i < 20 && mem_req !== 1'b1; i++) tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin
            errors++;
            $display("FAIL restart_req: req=%b addr=%h, want 1/00", mem_req, mem_addr);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({pc_wr_en, pc_next, mem_req, mem_addr, instr_valid,
             instr_out, instr_pc, fetch_err} !== '0) begin
            errors++;
            $display("FAIL midwait_reset: wr=%b nx=%h req=%b addr=%h v=%b err=%b, want all 0",
                     pc_wr_en, pc_next, mem_req, mem_addr, instr_valid, fetch_err);
        end
        tick();
        checks++;
        if (pc_wr_en !== 1'b1 || pc_next !== 8'h00) begin
            errors++;
            $display("FAIL midwait_init: wr=%b nx=%h, want 1/00", pc_wr_en, pc_next);
        end
        tick();
        checks++;
        if (pc_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL midwait_pulse: wr=%b, want 0", pc_wr_en);
        end
        for (int i = 0; i < 20 && instr_valid !== 1'b1; i++) tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 8'h00 || instr_out !== 8'h5A) begin
            errors++;
            $display("FAIL midwait_fetch: v=%b pc=%h out=%h, want 1/00/5a",
                     instr_valid, instr_pc, instr_out);
        end
    endtask

    initial begin
        test_reset();
        test_seq_fetch();
        test_wrap();
        test_hold_stall();
        test_branch_on_ack();
        test_timeout();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
